// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (subtractor today,
// adder/comparator later): common FSM state type and its encoding.
package serial_arith_pkg;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_RUN_ENC  = 2'd1;
   localparam logic [1:0] ST_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_RUN  = ST_RUN_ENC,
      ST_DONE = ST_DONE_ENC
   } serial_state_e;

   // Bit-counter width; never below 1 so the smallest legal WIDTH still has a counter.
   function automatic int serial_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: two half-subtractor stages with the stage borrows ORed.
module full_subtractor_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   logic hs1_d, hs1_b, hs2_b;

   assign hs1_d  = a_i ^ b_i;
   assign hs1_b  = ~a_i & b_i;
   assign d_o    = hs1_d ^ bin_i;
   assign hs2_b  = ~hs1_d & bin_i;
   assign bout_o = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b, borrow = (a < b).
// One bit per clock; operands and result each cross a valid/ready handshake.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int            CW   = serial_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   serial_state_e    state_q;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bflop_q;
   logic             borrow_q;
   logic             out_valid_q;
   logic             cell_d, cell_bout;

   full_subtractor_cell u_cell (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .bin_i  (bflop_q),
      .d_o    (cell_d),
      .bout_o (cell_bout)
   );

   always_comb begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      diff_d = {cell_d, diff_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         bflop_q     <= 1'b0;
         borrow_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  cnt_q   <= '0;
                  bflop_q <= 1'b0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh_q  <= a_sh_d;
               b_sh_q  <= b_sh_d;
               diff_q  <= diff_d;
               bflop_q <= cell_bout;
               // Counter stops at LAST: the exit edge moves to DONE instead of wrapping.
               if (cnt_q == LAST) begin
                  borrow_q    <= cell_bout;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // Masked by rst so the source never sees ready while the block is held in reset.
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule
